// File: rtl/bin2bcd_multi_pkg.sv
// Shared FSM encoding, blank code and digit-count helper for the
// multi-channel binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        DONE
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Each decimal digit holds more than 3 bits of range, so this always covers 2^width-1.
    function automatic int full_digits(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/bin2bcd_multi_if.sv
// Request/result bundle between a display controller (master) and the
// converter (slave).
interface bin2bcd_multi_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 12,
    parameter int DIGITS   = 4
);
    logic                         start;
    logic [CHANNELS*WIDTH-1:0]    bin_in;
    logic                         busy;
    logic                         done;
    logic [CHANNELS*DIGITS*4-1:0] bcd_out;
    logic [CHANNELS-1:0]          ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bin2bcd_multi_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// accumulator left by one bit taking i_msb into the units digit.
module bcd_dabble_step #(
    parameter int FULL = 4
) (
    input  logic [FULL*4-1:0] i_acc,
    input  logic              i_msb,
    output logic [FULL*4-1:0] o_acc
);
    logic [FULL*4-1:0] w_adj;

    always_comb begin
        // NOTE: the whole vector is assigned before any per-digit overwrite so no latch can form.
        w_adj = i_acc;
        for (int d = 0; d < FULL; d++) begin
            if (i_acc[d*4 +: 4] >= 4'd5) begin
                w_adj[d*4 +: 4] = i_acc[d*4 +: 4] + 4'd3;
            end
        end
    end

    // The top bit falling off is always zero because FULL digits cover the input range.
    assign o_acc = (w_adj << 1) | (FULL*4)'(i_msb);

endmodule

// File: rtl/bin2bcd_multi.sv
// Multi-channel binary-to-BCD converter: snapshots all channels on start,
// converts them one after another through a shared dabble step, and
// publishes every digit group together with a one-cycle done pulse.
module bin2bcd_multi
    import bin2bcd_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 12,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 0
) (
    input logic             clk,
    input logic             rst,
    bin2bcd_multi_if.slave  bus
);
    localparam int FULL  = full_digits(WIDTH);
    localparam int NDIG  = (FULL > DIGITS) ? FULL : DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int GRP_W = DIGITS * 4;

    state_t                      r_state;
    logic [CHANNELS*WIDTH-1:0]   r_cap;
    logic [WIDTH-1:0]            r_shift;
    logic [FULL*4-1:0]           r_acc;
    logic [CNT_W-1:0]            r_cnt;
    logic [CH_W-1:0]             r_ch;
    logic [CHANNELS*GRP_W-1:0]   r_shadow_bcd;
    logic [CHANNELS-1:0]         r_shadow_ovf;
    logic [CHANNELS*GRP_W-1:0]   r_bcd;
    logic [CHANNELS-1:0]         r_ovf;
    logic                        r_busy;
    logic                        r_done;

    logic [FULL*4-1:0]           w_acc_next;
    logic [NDIG*4-1:0]           w_acc_ext;
    logic [GRP_W-1:0]            w_group;
    logic                        w_sat;
    logic                        w_lead;

    bcd_dabble_step #(.FULL(FULL)) u_step (
        .i_acc (r_acc),
        .i_msb (r_shift[WIDTH-1]),
        .o_acc (w_acc_next)
    );

    // Result group for the channel just converted: saturate, else truncate and optionally blank.
    always_comb begin
        w_acc_ext              = '0;
        w_acc_ext[FULL*4-1:0]  = r_acc;
        w_sat                  = 1'b0;
        w_group                = '0;
        w_lead                 = 1'b1;
        for (int d = DIGITS; d < NDIG; d++) begin
            if (w_acc_ext[d*4 +: 4] != 4'd0) begin
                w_sat = 1'b1;
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            w_group[d*4 +: 4] = w_sat ? 4'd9 : w_acc_ext[d*4 +: 4];
        end
        if (BLANK_LZ != 0 && !w_sat) begin
            for (int d = DIGITS - 1; d > 0; d--) begin
                if (w_lead && w_group[d*4 +: 4] == 4'd0) begin
                    w_group[d*4 +: 4] = BLANK_CODE;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
        if (rst) begin
            r_state      <= IDLE;
            r_cap        <= '0;
            r_shift      <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ch         <= '0;
            r_shadow_bcd <= '0;
            r_shadow_ovf <= '0;
            r_bcd        <= '0;
            r_ovf        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // busy is still high during the done cycle, so a start there is dropped.
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (bus.start) begin
                        r_cap   <= bus.bin_in;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_shift <= r_cap[r_ch*WIDTH +: WIDTH];
                    r_acc   <= '0;
                    r_cnt   <= CNT_W'(WIDTH);
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= STORE;
                    end
                end
                STORE: begin
                    r_shadow_bcd[r_ch*GRP_W +: GRP_W] <= w_group;
                    r_shadow_ovf[r_ch]                <= w_sat;
                    if (r_ch == CH_W'(CHANNELS - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_state <= LOAD;
                    end
                end
                DONE: begin
                    r_bcd   <= r_shadow_bcd;
                    r_ovf   <= r_shadow_ovf;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd;
    assign bus.ovf     = r_ovf;

endmodule
